// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared pipeline control types and constants
package hazard_stall_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  // Instruction word loaded into a flushed pipeline register
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    HALT       = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// rtl/hazard_stall_ctrl_load_use_detect.sv - combinational load-use hazard compare
// Ports:
//   idRs, idRt, idRtUsed : source operands of the instruction in ID
//   idexMemRead, idexRt  : load in EX and its destination register
//   hazard               : ID consumes the load result one cycle too early
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idRtUsed,
  input  logic                  idexMemRead,
  input  logic [REG_ADDR_W-1:0] idexRt,
  output logic                  hazard
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign hazard = idexMemRead && (idexRt != '0) &&
                  ((idexRt == idRs) || (idRtUsed && (idexRt == idRt)));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - stall/flush/halt controller for PC, IF/ID and ID/EX
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   idRs/idRt/idRtUsed    : ID source operands
//   idHalt                : ID holds HALT
//   idexMemRead/idexRt    : load in EX
//   exTaken               : branch/jump resolved taken in EX
//   pcNotEnable, ifidNotEnable, ifidFlush, idexFlush, halted : registered controls
//   stallCount            : saturating count of load-use stall cycles
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idRtUsed,
  input  logic                  idHalt,
  input  logic                  idexMemRead,
  input  logic [REG_ADDR_W-1:0] idexRt,
  input  logic                  exTaken,
  output logic                  pcNotEnable,
  output logic                  ifidNotEnable,
  output logic                  ifidFlush,
  output logic                  idexFlush,
  output logic                  halted,
  output logic [CNT_W-1:0]      stallCount
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state, stateNext;
  logic [1:0] flushCnt, flushCntNext;
  logic       hazard;
  logic       pcNext, ifidNeNext, ifidFlNext, idexFlNext, haltedNext;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .idRs        (idRs),
    .idRt        (idRt),
    .idRtUsed    (idRtUsed),
    .idexMemRead (idexMemRead),
    .idexRt      (idexRt),
    .hazard      (hazard)
  );

  always_comb begin
    stateNext    = state;
    flushCntNext = flushCnt;
    case (state)
      RUN: begin
        // a taken branch squashes any halt or hazard sitting behind it
        if (exTaken) begin
          stateNext    = FLUSH;
          flushCntNext = FLUSH_RELOAD;
        end else if (idHalt) begin
          stateNext = HALT;
        end else if (hazard) begin
          stateNext = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (exTaken) begin
          stateNext    = FLUSH;
          flushCntNext = FLUSH_RELOAD;
        end else begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        if (exTaken) begin
          flushCntNext = FLUSH_RELOAD;
        end else if (flushCnt == 2'd0) begin
          stateNext = RUN;
        end else begin
          flushCntNext = flushCnt - 2'd1;
        end
      end
      HALT: stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it, so
  // they are a pure function of the current state and glitch-free by the
  // falling edge where the pipeline registers capture.
  always_comb begin
    pcNext     = 1'b0;
    ifidNeNext = 1'b0;
    ifidFlNext = 1'b0;
    idexFlNext = 1'b0;
    haltedNext = 1'b0;
    case (stateNext)
      LOAD_STALL: begin
        pcNext     = 1'b1;
        ifidNeNext = 1'b1;
        idexFlNext = 1'b1;
      end
      FLUSH: begin
        ifidFlNext = 1'b1;
        idexFlNext = 1'b1;
      end
      HALT: begin
        pcNext     = 1'b1;
        ifidNeNext = 1'b1;
        idexFlNext = 1'b1;
        haltedNext = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      flushCnt      <= 2'd0;
      pcNotEnable   <= 1'b0;
      ifidNotEnable <= 1'b0;
      ifidFlush     <= 1'b0;
      idexFlush     <= 1'b0;
      halted        <= 1'b0;
      stallCount    <= '0;
    end else begin
      state         <= stateNext;
      flushCnt      <= flushCntNext;
      pcNotEnable   <= pcNext;
      ifidNotEnable <= ifidNeNext;
      ifidFlush     <= ifidFlNext;
      idexFlush     <= idexFlNext;
      halted        <= haltedNext;
      // counted on entry so the count already includes the visible stall cycle
      if (stateNext == LOAD_STALL && stallCount != '1)
        stallCount <= stallCount + CNT_W'(1);
    end
  end

endmodule
